// File: rtl/divider_int_multich.sv
// divider_int_multich: multi-channel integer clock divider.
// Each channel divides clk by any ratio >= 2 (odd ratios included) and has
// its own run enable. It produces a registered divided clock plus a one-cycle
// strobe at the start of every output period. A new ratio is taken only at a
// period boundary. A shared sync pulse phase-aligns all enabled channels.
module divider_int_multich #(
  parameter int WIDTH_NUM_DIV = 4,
  parameter int NUM_CH        = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_CH-1:0]                 en,
  input  logic                              sync,
  input  logic [NUM_CH*WIDTH_NUM_DIV-1:0]   num_div,
  output logic [NUM_CH-1:0]                 clk_div,
  output logic [NUM_CH-1:0]                 div_stb,
  output logic [NUM_CH*WIDTH_NUM_DIV-1:0]   cur_div
);

  localparam int W = WIDTH_NUM_DIV;

  logic [W-1:0]      cnt_q [NUM_CH];
  logic [W-1:0]      cnt_d [NUM_CH];
  logic [W-1:0]      act_q [NUM_CH];
  logic [W-1:0]      act_d [NUM_CH];
  logic [NUM_CH-1:0] clk_d;
  logic [NUM_CH-1:0] stb_d;

  // Next-state per channel: park while disabled, wrap at terminal count or
  // sync, otherwise advance the phase counter and derive the output level.
  always_comb begin
    logic [W-1:0] req;
    logic [W-1:0] san;
    logic [W:0]   hi;
    logic [W:0]   nxt;
    logic         wrap;
    req  = '0;
    san  = '0;
    hi   = '0;
    nxt  = '0;
    wrap = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      act_d[i] = act_q[i];
      clk_d[i] = 1'b0;
      stb_d[i] = 1'b0;

      req = num_div[i*W +: W];
      san = (req < W'(2)) ? W'(2) : req;
      // High time is computed one bit wider so the largest ratio cannot overflow.
      hi  = ({1'b0, act_q[i]} + 1'b1) >> 1;
      nxt = {1'b0, cnt_q[i]} + 1'b1;
      // A sync on the natural terminal count is still a single wrap.
      wrap = (cnt_q[i] == (act_q[i] - 1'b1)) | sync;

      if (!en[i]) begin
        // Parked at terminal count so the first enabled edge wraps.
        act_d[i] = san;
        cnt_d[i] = san - 1'b1;
      end else if (wrap) begin
        cnt_d[i] = '0;
        act_d[i] = san;
        clk_d[i] = 1'b1;
        stb_d[i] = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
        clk_d[i] = (nxt < hi);
      end
    end
  end

  // State and output registers; reset leaves every channel ready to wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= W'(1);
        act_q[i] <= W'(2);
      end
      clk_div <= '0;
      div_stb <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
        act_q[i] <= act_d[i];
      end
      clk_div <= clk_d;
      div_stb <= stb_d;
    end
  end

  // Expose the ratio currently in effect for each channel.
  always_comb begin
    cur_div = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cur_div[i*W +: W] = act_q[i];
    end
  end

endmodule

// File: tb/tb_divider_int_multich.sv
// Directed self-checking bench for divider_int_multich (W=4, 2 channels).
module tb_divider_int_multich;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] en;
  logic       sync;
  logic [7:0] num_div;
  logic [1:0] clk_div;
  logic [1:0] div_stb;
  logic [7:0] cur_div;

  int checks = 0;
  int errors = 0;

  divider_int_multich #(.WIDTH_NUM_DIV(4), .NUM_CH(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .sync    (sync),
    .num_div (num_div),
    .clk_div (clk_div),
    .div_stb (div_stb),
    .cur_div (cur_div)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle for sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Disable ch0, load a ratio and let it park for one edge.
  task automatic park0(input logic [3:0] n);
    en[0] = 1'b0;
    num_div[3:0] = n;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 2'b00; sync = 1'b0; num_div = 8'h32;
    #3;
    checks++;
    if (clk_div !== 2'b00) begin errors++; $display("FAIL reset_clk got %b exp 00", clk_div); end
    checks++;
    if (div_stb !== 2'b00) begin errors++; $display("FAIL reset_stb got %b exp 00", div_stb); end
    checks++;
    if (cur_div !== 8'h22) begin errors++; $display("FAIL reset_cur got %h exp 22", cur_div); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_ratio2();
    bit [0:5] ec = 6'b101010;
    bit [0:5] es = 6'b101010;
    en[0] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if (clk_div[0] !== ec[k]) begin errors++; $display("FAIL r2_clk e%0d got %b exp %b", k, clk_div[0], ec[k]); end
      checks++;
      if (div_stb[0] !== es[k]) begin errors++; $display("FAIL r2_stb e%0d got %b exp %b", k, div_stb[0], es[k]); end
      checks++;
      if (clk_div[1] !== 1'b0) begin errors++; $display("FAIL r2_ch1_off e%0d got %b exp 0", k, clk_div[1]); end
    end
    checks++;
    if (cur_div !== 8'h32) begin errors++; $display("FAIL r2_cur got %h exp 32", cur_div); end
  endtask

  task automatic test_ratio5();
    bit [0:9] ec = 10'b1110011100;
    bit [0:9] es = 10'b1000010000;
    park0(4'd5);
    checks++;
    if (cur_div[3:0] !== 4'd5) begin errors++; $display("FAIL r5_park_cur got %0d exp 5", cur_div[3:0]); end
    checks++;
    if (clk_div[0] !== 1'b0) begin errors++; $display("FAIL r5_park_clk got %b exp 0", clk_div[0]); end
    en[0] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if (clk_div[0] !== ec[k]) begin errors++; $display("FAIL r5_clk e%0d got %b exp %b", k, clk_div[0], ec[k]); end
      checks++;
      if (div_stb[0] !== es[k]) begin errors++; $display("FAIL r5_stb e%0d got %b exp %b", k, div_stb[0], es[k]); end
    end
  endtask

  task automatic test_change();
    bit [0:11] ec = 12'b110011110001;
    bit [0:11] es = 12'b100010000001;
    logic [3:0] ecur;
    park0(4'd4);
    en[0] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (k == 2) num_div[3:0] = 4'd7;
      tick();
      ecur = (k < 4) ? 4'd4 : 4'd7;
      checks++;
      if (clk_div[0] !== ec[k]) begin errors++; $display("FAIL chg_clk e%0d got %b exp %b", k, clk_div[0], ec[k]); end
      checks++;
      if (div_stb[0] !== es[k]) begin errors++; $display("FAIL chg_stb e%0d got %b exp %b", k, div_stb[0], es[k]); end
      checks++;
      if (cur_div[3:0] !== ecur) begin errors++; $display("FAIL chg_cur e%0d got %0d exp %0d", k, cur_div[3:0], ecur); end
    end
  endtask

  task automatic test_illegal();
    bit [0:3] ec = 4'b1010;
    for (int n = 0; n < 2; n++) begin
      park0(4'(n));
      checks++;
      if (cur_div[3:0] !== 4'd2) begin errors++; $display("FAIL ill%0d_park_cur got %0d exp 2", n, cur_div[3:0]); end
      en[0] = 1'b1;
      for (int k = 0; k < 4; k++) begin
        tick();
        checks++;
        if (clk_div[0] !== ec[k]) begin errors++; $display("FAIL ill%0d_clk e%0d got %b exp %b", n, k, clk_div[0], ec[k]); end
        checks++;
        if (div_stb[0] !== ec[k]) begin errors++; $display("FAIL ill%0d_stb e%0d got %b exp %b", n, k, div_stb[0], ec[k]); end
      end
      checks++;
      if (cur_div[3:0] !== 4'd2) begin errors++; $display("FAIL ill%0d_cur got %0d exp 2", n, cur_div[3:0]); end
    end
  endtask

  task automatic test_sync();
    bit [0:12] c0 = 13'b1110111000111;
    bit [0:12] s0 = 13'b1000100000101;
    bit [0:12] c1 = 13'b1111110000000;
    bit [0:12] s1 = 13'b1000100000000;
    en = 2'b00;
    num_div = {4'd9, 4'd6};
    tick();
    en = 2'b11;
    for (int k = 0; k < 13; k++) begin
      sync = (k == 4 || k == 10 || k == 12);
      if (k == 6) en[1] = 1'b0;
      tick();
      sync = 1'b0;
      checks++;
      if (clk_div[0] !== c0[k]) begin errors++; $display("FAIL sync_clk0 e%0d got %b exp %b", k, clk_div[0], c0[k]); end
      checks++;
      if (div_stb[0] !== s0[k]) begin errors++; $display("FAIL sync_stb0 e%0d got %b exp %b", k, div_stb[0], s0[k]); end
      checks++;
      if (clk_div[1] !== c1[k]) begin errors++; $display("FAIL sync_clk1 e%0d got %b exp %b", k, clk_div[1], c1[k]); end
      checks++;
      if (div_stb[1] !== s1[k]) begin errors++; $display("FAIL sync_stb1 e%0d got %b exp %b", k, div_stb[1], s1[k]); end
    end
    checks++;
    if (cur_div !== 8'h96) begin errors++; $display("FAIL sync_cur got %h exp 96", cur_div); end
  endtask

  task automatic test_reset_mid();
    bit [0:15] ec = 16'b1111111100000001;
    bit [0:15] es = 16'b1000000000000001;
    park0(4'd15);
    en[0] = 1'b1;
    tick();
    tick();
    checks++;
    if (clk_div[0] !== 1'b1) begin errors++; $display("FAIL rmid_pre_clk got %b exp 1", clk_div[0]); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (clk_div !== 2'b00) begin errors++; $display("FAIL rmid_async_clk got %b exp 00", clk_div); end
    checks++;
    if (cur_div !== 8'h22) begin errors++; $display("FAIL rmid_async_cur got %h exp 22", cur_div); end
    tick();
    checks++;
    if (clk_div !== 2'b00) begin errors++; $display("FAIL rmid_hold_clk got %b exp 00", clk_div); end
    rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      tick();
      checks++;
      if (clk_div[0] !== ec[k]) begin errors++; $display("FAIL rmid_clk e%0d got %b exp %b", k, clk_div[0], ec[k]); end
      checks++;
      if (div_stb[0] !== es[k]) begin errors++; $display("FAIL rmid_stb e%0d got %b exp %b", k, div_stb[0], es[k]); end
    end
    checks++;
    if (cur_div[3:0] !== 4'd15) begin errors++; $display("FAIL rmid_cur got %0d exp 15", cur_div[3:0]); end
  endtask

  initial begin
    test_reset();
    test_ratio2();
    test_ratio5();
    test_change();
    test_illegal();
    test_sync();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
